macc_seq_ctrl: RTL and testbench

Sequencing controller for the int8 filter/input multiply-accumulate datapath, presented on the CPU's CFU command/response bus. The CPU pushes packed word pairs into a small FIFO; an internal engine drains it one int8 lane per cycle into a 32-bit accumulator. Commands that need a quiescent datapath are back-pressured until it is quiescent. The block replaces the single-cycle combinational MAC so the CPU can issue pushes back-to-back while the MAC runs.

---
 rtl/macc_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_macc_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_seq_ctrl.sv
// Queued int8 multiply-accumulate engine behind a CFU command/response bus.
// Word pairs are buffered in a small FIFO and consumed one lane per cycle.
module macc_seq_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_payload_response_ok,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [2:0] OP_SET_OFFSET = 3'd0;
  localparam logic [2:0] OP_SET_ACC    = 3'd1;
  localparam logic [2:0] OP_PUSH       = 3'd2;
  localparam logic [2:0] OP_READ_ACC   = 3'd3;
  localparam logic [2:0] OP_STATUS     = 3'd4;

  typedef enum logic {ST_IDLE, ST_MAC} state_t;

  state_t        state_q;
  logic [1:0]    lane_q;
  logic [31:0]   filt_q;
  logic [31:0]   inp_q;
  logic [31:0]   acc_q;
  logic [31:0]   offset_q;

  logic [31:0]   mem_filt [FIFO_DEPTH];
  logic [31:0]   mem_inp  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic          rsp_valid_q;
  logic          rsp_ok_q;
  logic [31:0]   rsp_data_q;
  logic          rsp_ok_d;
  logic [31:0]   rsp_data_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          quiescent;
  logic          rsp_free;
  logic          op_allowed;
  logic          accept;
  logic          push;
  logic          pop;

  logic [7:0]         filt_byte;
  logic [7:0]         inp_byte;
  logic signed [31:0] filt_ext;
  logic signed [31:0] inp_ext;
  logic signed [31:0] inp_biased;
  logic signed [31:0] product;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign quiescent  = (state_q == ST_IDLE) && fifo_empty;
  assign rsp_free   = !rsp_valid_q || rsp_ready;

  always_comb begin
    op_allowed = 1'b1;
    case (cmd_payload_function_id)
      OP_SET_OFFSET, OP_SET_ACC, OP_READ_ACC: op_allowed = quiescent;
      OP_PUSH:                                op_allowed = !fifo_full;
      default:                                op_allowed = 1'b1;
    endcase
  end

  assign cmd_ready = rsp_free && op_allowed;
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && (cmd_payload_function_id == OP_PUSH);
  // Pop on entry from IDLE or on the last lane, so back-to-back pairs have no bubble.
  assign pop       = !fifo_empty && ((state_q == ST_IDLE) || (lane_q == 2'd3));
  assign count_d   = count_q + CW'(push) - CW'(pop);

  assign filt_byte  = filt_q[{lane_q, 3'b000} +: 8];
  assign inp_byte   = inp_q[{lane_q, 3'b000} +: 8];
  assign filt_ext   = {{24{filt_byte[7]}}, filt_byte};
  assign inp_ext    = {{24{inp_byte[7]}}, inp_byte};
  assign inp_biased = inp_ext + $signed(offset_q);
  assign product    = filt_ext * inp_biased;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_filt[wr_ptr_q] <= cmd_payload_inputs_0;
      mem_inp[wr_ptr_q]  <= cmd_payload_inputs_1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      lane_q   <= 2'd0;
      filt_q   <= '0;
      inp_q    <= '0;
      acc_q    <= '0;
      offset_q <= '0;
    end else begin
      if (accept && (cmd_payload_function_id == OP_SET_OFFSET))
        offset_q <= cmd_payload_inputs_0;
      // SET_ACC only lands while quiescent, so it never races a MAC update.
      if (accept && (cmd_payload_function_id == OP_SET_ACC))
        acc_q <= cmd_payload_inputs_0;
      else if (state_q == ST_MAC)
        acc_q <= acc_q + product;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            filt_q  <= mem_filt[rd_ptr_q];
            inp_q   <= mem_inp[rd_ptr_q];
            lane_q  <= 2'd0;
            state_q <= ST_MAC;
          end
        end
        default: begin
          lane_q <= lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            if (pop) begin
              filt_q <= mem_filt[rd_ptr_q];
              inp_q  <= mem_inp[rd_ptr_q];
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    rsp_ok_d   = 1'b1;
    rsp_data_d = '0;
    case (cmd_payload_function_id)
      OP_SET_OFFSET, OP_SET_ACC: rsp_data_d = '0;
      OP_PUSH:                   rsp_data_d = 32'(count_d);
      OP_READ_ACC:               rsp_data_d = acc_q;
      OP_STATUS:                 rsp_data_d = {30'b0, (state_q == ST_MAC), fifo_full};
      default: begin
        rsp_ok_d   = 1'b0;
        rsp_data_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_ok_q    <= rsp_ok_d;
      rsp_data_q  <= rsp_data_d;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid               = rsp_valid_q;
  assign rsp_payload_response_ok = rsp_ok_q;
  assign rsp_payload_outputs_0   = rsp_data_q;

endmodule

// File: tb/tb_macc_seq_ctrl.sv
// Bench for macc_seq_ctrl: queue/countdown reference model checked every cycle,
// directed scenarios with literal results, then randomized traffic.
module tb_macc_seq_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_payload_response_ok;
  logic [31:0] rsp_payload_outputs_0;

  macc_seq_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_response_ok (rsp_payload_response_ok),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending pairs as a queue, engine as a lane countdown,
  // acc advanced by the whole dot product when a pair is pushed.
  int          m_q[$];
  int          m_eng_left;
  logic [31:0] m_acc, m_off;
  logic        m_rvalid, m_rok;
  logic [31:0] m_rdata;

  logic        s_ready, s_rvalid, s_rok;
  logic [31:0] s_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dot(input logic [31:0] f, input logic [31:0] i, input logic [31:0] off);
    int sum = 0;
    for (int k = 0; k < 4; k++) begin
      int fb, ib;
      fb = int'($signed(f[8*k +: 8]));
      ib = int'($signed(i[8*k +: 8]));
      sum = sum + fb * (ib + int'(off));
    end
    return sum;
  endfunction

  function automatic logic m_ready(input logic [2:0] f);
    logic free, quiet;
    free  = !m_rvalid || rsp_ready;
    quiet = (m_eng_left == 0) && (m_q.size() == 0);
    case (f)
      3'd0, 3'd1, 3'd3: return free && quiet;
      3'd2:             return free && (m_q.size() < DEPTH);
      default:          return free;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_eng_left = 0;
    m_acc = 0; m_off = 0;
    m_rvalid = 0; m_rok = 0; m_rdata = 0;
  endtask

  task automatic model_update();
    logic acc_ok, pop, busy0, full0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    acc_ok = cmd_valid && m_ready(cmd_payload_function_id);
    busy0  = (m_eng_left > 0);
    full0  = (m_q.size() == DEPTH);
    pop    = (m_q.size() > 0) && (m_eng_left <= 1);
    if (m_eng_left > 0) m_eng_left--;
    if (pop) begin
      void'(m_q.pop_front());
      m_eng_left = 4;
    end
    if (acc_ok) begin
      m_rvalid = 1; m_rok = 1; m_rdata = 0;
      case (cmd_payload_function_id)
        3'd0: m_off = cmd_payload_inputs_0;
        3'd1: m_acc = cmd_payload_inputs_0;
        3'd2: begin
          m_acc = m_acc + dot(cmd_payload_inputs_0, cmd_payload_inputs_1, m_off);
          m_q.push_back(1);
          m_rdata = m_q.size();
        end
        3'd3: m_rdata = m_acc;
        3'd4: m_rdata = {30'b0, busy0, full0};
        default: m_rok = 0;
      endcase
    end else if (rsp_ready) begin
      m_rvalid = 0;
    end
  endtask

  // One cycle: sample and compare just after the falling edge, then advance the model.
  task automatic tick();
    #1;
    s_ready  = cmd_ready;
    s_rvalid = rsp_valid;
    s_rok    = rsp_payload_response_ok;
    s_rdata  = rsp_payload_outputs_0;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rvalid));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ready(cmd_payload_function_id)));
    if (m_rvalid) begin
      chk("rsp_ok", 32'(rsp_payload_response_ok), 32'(m_rok));
      chk("rsp_data", rsp_payload_outputs_0, m_rdata);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_cmd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] d, output logic ok);
    int n = 0;
    cmd_valid = 1; cmd_payload_function_id = f;
    cmd_payload_inputs_0 = a; cmd_payload_inputs_1 = b;
    do begin tick(); n++; end while (!s_ready && n < 300);
    cmd_valid = 0;
    if (!s_ready) chk("cmd_accept_timeout", 32'(s_ready), 32'd1);
    n = 0;
    do begin tick(); n++; end while (!s_rvalid && n < 10);
    if (!s_rvalid) chk("rsp_timeout", 32'(s_rvalid), 32'd1);
    d = s_rdata; ok = s_rok;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        ok;
    int          pushes, n;
    logic        saw_stall;

    reset_n = 0; cmd_valid = 0; cmd_payload_function_id = 0;
    cmd_payload_inputs_0 = 0; cmd_payload_inputs_1 = 0; rsp_ready = 1;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1;
    #1 chk("ready_after_reset", 32'(cmd_ready), 32'd1);
    chk("rsp_valid_after_reset", 32'(rsp_valid), 32'd0);
    @(negedge clk);

    do_cmd(3'd4, 0, 0, d, ok);
    chk("status_after_reset", d, 32'h0);
    chk("status_ok", 32'(ok), 32'd1);
    do_cmd(3'd6, 32'h1234, 32'h5678, d, ok);
    chk("op6_ok", 32'(ok), 32'd0);
    chk("op6_data", d, 32'h0);

    do_cmd(3'd0, 0, 0, d, ok);
    do_cmd(3'd1, 0, 0, d, ok);
    do_cmd(3'd2, 32'h04030201, 32'h01010101, d, ok);
    chk("push_count_1", d, 32'd1);
    do_cmd(3'd3, 0, 0, d, ok);
    chk("dot_basic", d, 32'd10);

    do_cmd(3'd0, 32'd128, 0, d, ok);
    do_cmd(3'd1, 0, 0, d, ok);
    do_cmd(3'd2, 32'h01010101, 32'h80808080, d, ok);
    do_cmd(3'd3, 0, 0, d, ok);
    chk("offset_cancel", d, 32'h0);
    do_cmd(3'd1, 32'hFFFFFFF0, 0, d, ok);
    do_cmd(3'd2, 32'h7F7F7F7F, 32'h7F7F7F7F, d, ok);
    do_cmd(3'd3, 0, 0, d, ok);
    chk("offset_127", d, 32'h0001F9F4);

    do_cmd(3'd0, 0, 0, d, ok);
    do_cmd(3'd1, 0, 0, d, ok);
    cmd_valid = 1; cmd_payload_function_id = 3'd2;
    cmd_payload_inputs_0 = 32'h01010101; cmd_payload_inputs_1 = 32'h01010101;
    pushes = 0; n = 0; saw_stall = 0;
    while (pushes < 8 && n < 200) begin
      tick();
      if (s_ready) pushes++; else saw_stall = 1;
      if (s_rvalid) chk("push_rsp_le_depth", 32'(s_rdata <= 32'd4), 32'd1);
      n++;
    end
    cmd_valid = 0;
    chk("pushes_accepted", 32'(pushes), 32'd8);
    chk("full_backpressure", 32'(saw_stall), 32'd1);
    do_cmd(3'd3, 0, 0, d, ok);
    chk("acc_after_8", d, 32'd32);

    rsp_ready = 0;
    cmd_valid = 1; cmd_payload_function_id = 3'd2;
    cmd_payload_inputs_0 = 32'h02020202; cmd_payload_inputs_1 = 32'h01010101;
    n = 0;
    do begin tick(); n++; end while (!s_ready && n < 300);
    cmd_valid = 0; cmd_payload_function_id = 3'd4;
    repeat (10) tick();
    chk("stall_rsp_held", 32'(s_rvalid), 32'd1);
    chk("stall_ready_low", 32'(s_ready), 32'd0);
    cmd_valid = 1; rsp_ready = 1;
    tick();
    chk("accept_on_release", 32'(s_ready), 32'd1);
    cmd_valid = 0;
    tick();
    chk("status_after_drain", s_rdata, 32'h0);

    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 9);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_payload_function_id = (r < 4) ? 3'd2 : 3'($urandom_range(0, 7));
      cmd_payload_inputs_0 = $urandom;
      cmd_payload_inputs_1 = $urandom;
      if ($urandom_range(0, 3) == 0) cmd_payload_inputs_0 = 32'($signed(8'($urandom)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 0; rsp_ready = 1;
    repeat (30) tick();

    do_cmd(3'd1, 32'd5, 0, d, ok);
    cmd_valid = 1; cmd_payload_function_id = 3'd2;
    cmd_payload_inputs_0 = 32'h01020304; cmd_payload_inputs_1 = 32'h05060708;
    repeat (4) tick();
    cmd_valid = 0; rsp_ready = 0;
    tick();
    reset_n = 0;
    #1;
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_rsp_ok", 32'(rsp_payload_response_ok), 32'd0);
    chk("async_rst_rsp_data", rsp_payload_outputs_0, 32'h0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd1);
    model_reset();
    @(negedge clk);
    tick();
    reset_n = 1; rsp_ready = 1;
    do_cmd(3'd3, 0, 0, d, ok);
    chk("acc_after_reset", d, 32'h0);
    do_cmd(3'd4, 0, 0, d, ok);
    chk("status_after_mid_reset", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
